// File: rtl/wb_host_pkg.sv
// -----------------------------------------------------------------------------
// wb_host_pkg
// Definitions shared by the Wishbone-style host master and the slave it drives:
//   - host FSM state encoding
//   - bus widths (address, data) and timeout counter width
//   - slave address map constants
// -----------------------------------------------------------------------------
package wb_host_pkg;

   localparam int DATA_W = 128;
   localparam int ADR_W  = 5;
   localparam int CNT_W  = 16;

   // Slave address map. Addresses 0..REG_MAX are plain registers. Addresses
   // 20..31 are unmapped; the slave answers them with error_i.
   localparam logic [ADR_W-1:0] REG_MAX     = 5'd15;
   localparam logic [ADR_W-1:0] ADR_CMD     = 5'd16;
   localparam logic [ADR_W-1:0] ADR_FIFO_WR = 5'd17;
   localparam logic [ADR_W-1:0] ADR_FIFO_RD = 5'd18;
   localparam logic [ADR_W-1:0] ADR_DATA    = 5'd19;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_RESP    = 2'd2,
      ST_RELEASE = 2'd3
   } wb_state_e;

endpackage

// File: rtl/wb_timeout_ctr.sv
// -----------------------------------------------------------------------------
// wb_timeout_ctr
// Counts consecutive cycles while run is high and flags the cycle in which the
// TIMEOUT_CYCLES-th such cycle occurs. The count clears whenever run is low, so
// every new bus cycle starts from zero.
//
// Ports
//   clock   in   rising-edge clock
//   reset   in   synchronous, active-high reset
//   run     in   high while the host is waiting in ISSUE
//   expired out  high in the TIMEOUT_CYCLES-th consecutive run cycle
// -----------------------------------------------------------------------------
module wb_timeout_ctr
   import wb_host_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic clock,
   input  logic reset,
   input  logic run,
   output logic expired
);

   // The count holds N-1 during the N-th run cycle, so the terminal value is
   // one below the configured cycle count.
   localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = '0;
      if (run) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   assign expired = run && (count_q == TERM);

   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/wb_host_master.sv
// -----------------------------------------------------------------------------
// wb_host_master
// Single-outstanding Wishbone-style host master. Accepts one request, drives it
// onto the slave bus until the slave acks, returns a one-cycle response, then
// waits for the slave to drop ack before accepting the next request.
//
// Optional feature: define WB_HOST_MASTER_TIMEOUT_EN to abort a bus cycle after
// TIMEOUT_CYCLES cycles in ISSUE without ack (response reports error, data 0).
// Without it, ISSUE waits for ack indefinitely.
//
// Ports
//   clock, reset          rising-edge clock, synchronous active-high reset
//   req_valid/we/adr/data requester side: transaction to issue
//   req_ready             high in IDLE; request accepted when valid&ready
//   rsp_valid             one-cycle completion pulse
//   rsp_data, rsp_error   read data (0 for writes) and error/timeout flag
//   strobe_o, we_o, adr_o, wb_data_o   bus outputs to the slave
//   ack_i, error_i, wb_data_i          bus inputs from the slave
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | ready for a request; latch it and start the bus cycle
// ISSUE   | strobe high, address/data stable, waiting for ack (or timeout)
// RESP    | rsp_valid pulse with captured data/error, strobe low
// RELEASE | strobe low, waiting for the slave to drop ack
// -----------------------------------------------------------------------------
module wb_host_master
   import wb_host_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [ADR_W-1:0]  req_adr,
   input  logic [DATA_W-1:0] req_data,
   output logic              req_ready,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_error,
   output logic              strobe_o,
   output logic              we_o,
   output logic [ADR_W-1:0]  adr_o,
   output logic [DATA_W-1:0] wb_data_o,
   input  logic              ack_i,
   input  logic              error_i,
   input  logic [DATA_W-1:0] wb_data_i
);

   if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
      $error("wb_host_master: TIMEOUT_CYCLES must be in 1..65535");
   end

   wb_state_e         state_q,     state_d;
   logic              req_ready_q, req_ready_d;
   logic              strobe_q,    strobe_d;
   logic              we_q,        we_d;
   logic [ADR_W-1:0]  adr_q,       adr_d;
   logic [DATA_W-1:0] wdata_q,     wdata_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_data_q,  rsp_data_d;
   logic              rsp_error_q, rsp_error_d;

   logic              timeout_hit;

`ifdef WB_HOST_MASTER_TIMEOUT_EN
   wb_timeout_ctr #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout_ctr (
      .clock   (clock),
      .reset   (reset),
      .run     (state_q == ST_ISSUE),
      .expired (timeout_hit)
   );
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      req_ready_d = 1'b0;
      strobe_d    = strobe_q;
      we_d        = we_q;
      adr_d       = adr_q;
      wdata_d     = wdata_q;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;
      rsp_error_d = rsp_error_q;

      case (state_q)
         ST_IDLE: begin
            // req_ready_q gates acceptance so nothing is taken in the first
            // cycle after reset, when ready is still low.
            if (req_valid && req_ready_q) begin
               state_d  = ST_ISSUE;
               strobe_d = 1'b1;
               we_d     = req_we;
               adr_d    = req_adr;
               wdata_d  = req_data;
            end else begin
               req_ready_d = 1'b1;
            end
         end

         ST_ISSUE: begin
            // A real ack wins over a timeout landing in the same cycle.
            if (ack_i) begin
               state_d     = ST_RESP;
               strobe_d    = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_data_d  = we_q ? '0 : wb_data_i;
               rsp_error_d = error_i;
            end else if (timeout_hit) begin
               state_d     = ST_RESP;
               strobe_d    = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_data_d  = '0;
               rsp_error_d = 1'b1;
            end
         end

         ST_RESP: begin
            state_d = ST_RELEASE;
         end

         ST_RELEASE: begin
            // A slave still holding ack from the finished cycle must not be
            // mistaken for the ack of a new one.
            if (!ack_i) begin
               state_d     = ST_IDLE;
               req_ready_d = 1'b1;
            end
         end

         default: begin
            state_d  = ST_IDLE;
            strobe_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         req_ready_q <= 1'b0;
         strobe_q    <= 1'b0;
         we_q        <= 1'b0;
         adr_q       <= '0;
         wdata_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         req_ready_q <= req_ready_d;
         strobe_q    <= strobe_d;
         we_q        <= we_d;
         adr_q       <= adr_d;
         wdata_q     <= wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_error_q <= rsp_error_d;
      end
   end

   assign req_ready = req_ready_q;
   assign strobe_o  = strobe_q;
   assign we_o      = we_q;
   assign adr_o     = adr_q;
   assign wb_data_o = wdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_wb_host_master.sv
module tb_wb_host_master;
   import wb_host_pkg::*;

`ifdef WB_HOST_MASTER_TIMEOUT_EN
   localparam int T     = 8;
   localparam bit TO_EN = 1'b1;
`else
   localparam int T     = 255;
   localparam bit TO_EN = 1'b0;
`endif

   logic              clock;
   logic              reset;
   logic              req_valid;
   logic              req_we;
   logic [4:0]        req_adr;
   logic [127:0]      req_data;
   logic              req_ready;
   logic              rsp_valid;
   logic [127:0]      rsp_data;
   logic              rsp_error;
   logic              strobe_o;
   logic              we_o;
   logic [4:0]        adr_o;
   logic [127:0]      wb_data_o;
   logic              ack_i;
   logic              error_i;
   logic [127:0]      wb_data_i;

   int n_pass  = 0;
   int n_total = 0;

   wb_host_master #(.TIMEOUT_CYCLES(T)) dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .req_we    (req_we),
      .req_adr   (req_adr),
      .req_data  (req_data),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_error (rsp_error),
      .strobe_o  (strobe_o),
      .we_o      (we_o),
      .adr_o     (adr_o),
      .wb_data_o (wb_data_o),
      .ack_i     (ack_i),
      .error_i   (error_i),
      .wb_data_i (wb_data_i)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // One transaction: request fields, slave behaviour, expected outcome.
   // delay = cycles ack stays low in ISSUE; hold = cycles ack stays high
   // counting from the RESP cycle; latencies are cycles after acceptance.
   typedef struct {
      logic         we;
      logic [4:0]   adr;
      logic [127:0] data;
      int           delay;
      logic [127:0] rdata;
      logic         err;
      int           hold;
      logic [127:0] exp_data;
      logic         exp_err;
      int           exp_lat;
      int           exp_ready;
   } vec_t;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic vec_t mk(input logic we, input logic [4:0] adr, input logic [127:0] data,
                               input int delay, input logic [127:0] rdata, input logic err,
                               input int hold);
      vec_t v;
      v.we = we; v.adr = adr; v.data = data; v.delay = delay;
      v.rdata = rdata; v.err = err; v.hold = hold;
      v.exp_data = '0; v.exp_err = 1'b0; v.exp_lat = 0; v.exp_ready = 0;
      return v;
   endfunction

   // Reference model: response after the ack-low cycles plus two, or after T
   // ISSUE cycles on timeout; ready returns one cycle after the first cycle
   // past RESP in which ack is low.
   function automatic vec_t model(input vec_t v);
      vec_t r = v;
      if (TO_EN && v.delay >= T) begin
         r.exp_lat   = T + 1;
         r.exp_data  = '0;
         r.exp_err   = 1'b1;
         r.exp_ready = T + 3;
      end else begin
         r.exp_lat   = v.delay + 2;
         r.exp_data  = v.we ? 128'd0 : v.rdata;
         r.exp_err   = v.err;
         r.exp_ready = ((v.hold > 1) ? (r.exp_lat + v.hold) : (r.exp_lat + 1)) + 1;
      end
      return r;
   endfunction

   task automatic run_vec(input vec_t v, input string tag);
      int k, rsp_cnt, rsp_at, n_strobe, ready_at;
      bit acked, unstable;
      logic [127:0] got_data;
      logic got_err;
      @(negedge clock);
      check({tag, "_ready_idle"}, req_ready, 1);
      req_valid = 1'b1; req_we = v.we; req_adr = v.adr; req_data = v.data;
      ack_i = 1'b0; error_i = 1'b0; wb_data_i = rnd128();
      k = 0; rsp_cnt = 0; rsp_at = -1; n_strobe = 0; ready_at = -1;
      acked = 1'b0; unstable = 1'b0; got_data = '0; got_err = 1'b0;
      while (ready_at < 0 && k < 80) begin
         @(negedge clock);
         k++;
         req_valid = 1'b0; req_we = $urandom_range(0, 1) == 1;
         req_adr = 5'($urandom); req_data = rnd128();
         if (rsp_valid) begin
            rsp_cnt++;
            if (rsp_at < 0) begin
               rsp_at = k; got_data = rsp_data; got_err = rsp_error;
            end
         end
         if (adr_o !== v.adr || we_o !== v.we || wb_data_o !== v.data) unstable = 1'b1;
         if (req_ready) ready_at = k;
         if (strobe_o) begin
            n_strobe++;
            ack_i = (n_strobe - 1 >= v.delay);
            if (ack_i) acked = 1'b1;
         end else begin
            ack_i = acked && rsp_at >= 0 && (k - rsp_at < v.hold);
         end
         wb_data_i = ack_i ? v.rdata : rnd128();
         error_i   = ack_i ? v.err : ($urandom_range(0, 1) == 1);
      end
      ack_i = 1'b0;
      check({tag, "_rsp_count"}, rsp_cnt, 1);
      check({tag, "_latency"}, rsp_at, v.exp_lat);
      check({tag, "_rsp_data"}, got_data, v.exp_data);
      check({tag, "_rsp_error"}, got_err, v.exp_err);
      check({tag, "_strobe_cycles"}, n_strobe, v.exp_lat - 1);
      check({tag, "_ready_at"}, ready_at, v.exp_ready);
      check({tag, "_bus_stable"}, unstable, 0);
      check({tag, "_rsp_data_hold"}, rsp_data, v.exp_data);
   endtask

   vec_t tbl[5];

   initial begin
      int k, rsp_cnt, n_strobe, rsp_at;
      logic [127:0] got_data;
      logic got_err;

      // Hand table; expectations written directly from the behavioural rules.
      tbl[0] = mk(1'b1, 5'd3, 128'hA5, 1, 128'hDEAD, 1'b0, 0);
      tbl[0].exp_data = 0; tbl[0].exp_err = 0; tbl[0].exp_lat = 3; tbl[0].exp_ready = 5;
      tbl[1] = mk(1'b0, 5'd18, 128'h0, 0, 128'h1234_5678, 1'b0, 0);
      tbl[1].exp_data = 128'h1234_5678; tbl[1].exp_err = 0; tbl[1].exp_lat = 2; tbl[1].exp_ready = 4;
      tbl[2] = mk(1'b1, 5'd16, 128'hC0DE, 10, 128'h77, 1'b0, 3);
`ifdef WB_HOST_MASTER_TIMEOUT_EN
      tbl[2].exp_data = 0; tbl[2].exp_err = 1; tbl[2].exp_lat = 9; tbl[2].exp_ready = 11;
`else
      tbl[2].exp_data = 0; tbl[2].exp_err = 0; tbl[2].exp_lat = 12; tbl[2].exp_ready = 16;
`endif
      tbl[3] = mk(1'b0, 5'd25, 128'h0, 2, 128'hBEEF, 1'b1, 0);
      tbl[3].exp_data = 128'hBEEF; tbl[3].exp_err = 1; tbl[3].exp_lat = 4; tbl[3].exp_ready = 6;
      tbl[4] = mk(1'b1, 5'd19, 128'h5555, 5, 128'h99, 1'b0, 1);
      tbl[4].exp_data = 0; tbl[4].exp_err = 0; tbl[4].exp_lat = 7; tbl[4].exp_ready = 9;

      reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_adr = '0; req_data = '0;
      ack_i = 1'b0; error_i = 1'b0; wb_data_i = '0;

      // Reset state
      repeat (3) @(negedge clock);
      check("reset_outputs", {strobe_o, we_o, adr_o, wb_data_o, rsp_valid, rsp_data, rsp_error}, 0);
      check("reset_ready", req_ready, 0);
      reset = 1'b0;
      @(negedge clock);
      check("ready_after_reset", req_ready, 1);

      // Reset while in ISSUE: strobe drops, response discarded
      req_valid = 1'b1; req_we = 1'b0; req_adr = 5'd7; req_data = 128'h1;
      @(negedge clock);
      req_valid = 1'b0;
      check("rst_issue_strobe", strobe_o, 1);
      @(negedge clock);
      reset = 1'b1; ack_i = 1'b1; wb_data_i = 128'hFACE;
      @(negedge clock);
      check("rst_issue_strobe_drop", strobe_o, 0);
      check("rst_issue_no_rsp", rsp_valid, 0);
      check("rst_issue_ready_low", req_ready, 0);
      reset = 1'b0;
      @(negedge clock);
      check("rst_issue_ready_back", req_ready, 1);
      rsp_cnt = 0;
      repeat (3) begin
         @(negedge clock);
         if (rsp_valid) rsp_cnt++;
      end
      check("rst_issue_no_rsp_after", rsp_cnt, 0);
      ack_i = 1'b0;

      // Slave that never acks
      @(negedge clock);
      req_valid = 1'b1; req_we = 1'b1; req_adr = 5'd16; req_data = 128'hAB;
      rsp_cnt = 0; n_strobe = 0; rsp_at = -1; got_data = '1; got_err = 1'b0;
      for (k = 1; k <= 1000; k++) begin
         @(negedge clock);
         req_valid = 1'b0;
         wb_data_i = rnd128();
         if (strobe_o) n_strobe++;
         if (rsp_valid) begin
            rsp_cnt++;
            if (rsp_at < 0) begin
               rsp_at = k; got_data = rsp_data; got_err = rsp_error;
            end
         end
      end
`ifdef WB_HOST_MASTER_TIMEOUT_EN
      check("noack_rsp_count", rsp_cnt, 1);
      check("noack_issue_cycles", n_strobe, T);
      check("noack_rsp_at", rsp_at, T + 1);
      check("noack_rsp_error", got_err, 1);
      check("noack_rsp_data", got_data, 0);
`else
      check("noack_rsp_count", rsp_cnt, 0);
      check("noack_strobe_held", strobe_o, 1);
      check("noack_issue_cycles", n_strobe, 1000);
`endif
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);

      for (int i = 0; i < 5; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

      for (int i = 0; i < 40; i++) begin
         vec_t v;
         int d;
         d = ($urandom_range(0, 3) == 0) ? $urandom_range(6, 12) : $urandom_range(0, 5);
         v = mk($urandom_range(0, 1) == 1, 5'($urandom), rnd128(), d, rnd128(),
                $urandom_range(0, 3) == 0, $urandom_range(0, 3));
         run_vec(model(v), $sformatf("rnd%0d", i));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
